// File: rtl/cpu_vram_writer_if.sv
// Bus bundle between the 68000 snoop side and the external VRAM write port.
// The slave modport is the writer's view; master is the CPU/VRAM side.
interface cpu_vram_writer_if #(
  parameter int unsigned VRAM_AW = 15
);
  logic [23:1]        cpuAddr;
  logic [15:0]        cpuData;
  logic               ncpuAS;
  logic               ncpuUDS;
  logic               ncpuLDS;
  logic               cpuRnW;
  logic [VRAM_AW-1:0] vramAddr;
  logic [7:0]         vramDataOut;
  logic               vramDataOE;
  logic               nvramWE;

  modport slave (
    input  cpuAddr, cpuData, ncpuAS, ncpuUDS, ncpuLDS, cpuRnW,
    output vramAddr, vramDataOut, vramDataOE, nvramWE
  );

  modport master (
    output cpuAddr, cpuData, ncpuAS, ncpuUDS, ncpuLDS, cpuRnW,
    input  vramAddr, vramDataOut, vramDataOE, nvramWE
  );
endinterface

// File: rtl/cpu_vram_writer.sv
// Snoops 68000 framebuffer writes into a byte FIFO and retires them to VRAM in free video slots.
// Optional build macro ALT_BUFFER_EN enables snooping of the alternate screen buffer via altSel.
module cpu_vram_writer #(
  parameter logic [23:0] FB_BASE    = 24'h3FA700,
  parameter int unsigned FB_BYTES   = 21888,
  parameter int unsigned VRAM_AW    = 15,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter logic [23:0] ALT_OFFSET = 24'h008000
) (
  input  logic                         pixClk,
  input  logic                         reset,
  cpu_vram_writer_if.slave             bus,
  input  logic                         altSel,
  input  logic                         wrSlot,
  input  logic                         clrOverflow,
  output logic [$clog2(FIFO_DEPTH):0]  fifoLevel,
  output logic                         overflow
);

  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned EW = VRAM_AW + 8;
  localparam logic [PW:0] FULL_LVL = (PW + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {P_IDLE, P_HI, P_LO} pState_t;
  typedef enum logic [1:0] {W_IDLE, W_SETUP, W_STROBE, W_HOLD} wState_t;

  // ---------------- synchronizers ----------------
  logic [1:0] asSync, udsSync, ldsSync, rnwSync;
  logic       asS, udsS, ldsS, rnwS;
  logic       prevStb, armed;

  always_ff @(posedge pixClk) begin
    if (reset) begin
      asSync  <= '1;
      udsSync <= '1;
      ldsSync <= '1;
      rnwSync <= '1;
    end else begin
      asSync  <= {asSync[0],  bus.ncpuAS};
      udsSync <= {udsSync[0], bus.ncpuUDS};
      ldsSync <= {ldsSync[0], bus.ncpuLDS};
      rnwSync <= {rnwSync[0], bus.cpuRnW};
    end
  end

  assign asS  = asSync[1];
  assign udsS = udsSync[1];
  assign ldsS = ldsSync[1];
  assign rnwS = rnwSync[1];

  // ---------------- window decode ----------------
  logic [23:0] base;
  logic [23:0] byteAddr;
  logic [24:0] limit;
  logic        hit;
  logic [VRAM_AW-1:0] offset;

`ifdef ALT_BUFFER_EN
  logic [1:0] altSync;
  always_ff @(posedge pixClk) begin
    if (reset) altSync <= '0;
    else       altSync <= {altSync[0], altSel};
  end
  assign base = altSync[1] ? (FB_BASE - ALT_OFFSET) : FB_BASE;
`else
  logic unusedAltSel;
  assign unusedAltSel = altSel;
  assign base = FB_BASE;
`endif

  assign byteAddr = {bus.cpuAddr, 1'b0};
  assign limit    = {1'b0, base} + 25'(FB_BYTES);
  assign hit      = ({1'b0, byteAddr} >= {1'b0, base}) && ({1'b0, byteAddr} < limit);
  assign offset   = VRAM_AW'(byteAddr - base);

  logic capture, captureHit;
  // Strobe falling edge on the synced bus; armed limits this to one per AS cycle.
  assign capture    = !asS && !rnwS && !(udsS && ldsS) && prevStb && armed;
  assign captureHit = capture && hit;

  always_ff @(posedge pixClk) begin
    if (reset) begin
      prevStb <= 1'b1;
      armed   <= 1'b0;
    end else begin
      prevStb <= udsS && ldsS;
      if (asS)          armed <= 1'b1;
      else if (capture) armed <= 1'b0;
    end
  end

  // ---------------- push FSM ----------------
  pState_t            pState, pNext;
  logic [VRAM_AW-1:0] latOff;
  logic [15:0]        latData;
  logic               latLds;
  logic               latch, pushReq, captureDrop;
  logic [EW-1:0]      pushEntry;

  always_comb begin
    pNext       = pState;
    latch       = 1'b0;
    pushReq     = 1'b0;
    pushEntry   = '0;
    captureDrop = 1'b0;
    case (pState)
      P_IDLE: begin
        if (captureHit) begin
          latch = 1'b1;
          pNext = !udsS ? P_HI : P_LO;
        end
      end
      P_HI: begin
        pushReq   = 1'b1;
        pushEntry = {latOff, latData[15:8]};
        pNext     = latLds ? P_LO : P_IDLE;
      end
      P_LO: begin
        pushReq   = 1'b1;
        pushEntry = {latOff | VRAM_AW'(1), latData[7:0]};
        pNext     = P_IDLE;
      end
      default: pNext = P_IDLE;
    endcase
    if (captureHit && pState != P_IDLE) captureDrop = 1'b1;
  end

  always_ff @(posedge pixClk) begin
    if (reset) begin
      pState  <= P_IDLE;
      latOff  <= '0;
      latData <= '0;
      latLds  <= 1'b0;
    end else begin
      pState <= pNext;
      if (latch) begin
        latOff  <= offset;
        latData <= bus.cpuData;
        latLds  <= !ldsS;
      end
    end
  end

  // ---------------- FIFO ----------------
  logic [EW-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0] wrPtr, rdPtr;
  logic [PW:0]   count;
  logic          full, empty, pushOk, pushDrop, pop;
  logic [EW-1:0] head;

  assign full     = (count == FULL_LVL);
  assign empty    = (count == '0);
  // Fullness uses the registered level, so a same-cycle pop never makes room.
  assign pushOk   = pushReq && !full;
  assign pushDrop = pushReq && full;
  assign head     = mem[rdPtr];

  always_ff @(posedge pixClk) begin
    if (pushOk) mem[wrPtr] <= pushEntry;
  end

  always_ff @(posedge pixClk) begin
    if (reset) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (pushOk) wrPtr <= wrPtr + 1'b1;
      if (pop)    rdPtr <= rdPtr + 1'b1;
      case ({pushOk, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign fifoLevel = count;

  always_ff @(posedge pixClk) begin
    if (reset)                        overflow <= 1'b0;
    else if (pushDrop || captureDrop) overflow <= 1'b1;
    else if (clrOverflow)             overflow <= 1'b0;
  end

  // ---------------- VRAM write FSM ----------------
  wState_t            wState, wNext;
  logic               loadOut;
  logic [VRAM_AW-1:0] addrQ;
  logic [7:0]         dataQ;
  logic               oeQ, nweQ;

  always_comb begin
    wNext   = wState;
    loadOut = 1'b0;
    pop     = 1'b0;
    case (wState)
      W_IDLE: begin
        if (wrSlot && !empty) begin
          wNext   = W_SETUP;
          loadOut = 1'b1;
        end
      end
      W_SETUP:  wNext = W_STROBE;
      W_STROBE: wNext = W_HOLD;
      W_HOLD: begin
        pop   = 1'b1;
        wNext = W_IDLE;
      end
      default: wNext = W_IDLE;
    endcase
  end

  // Strobes are registered from the next state so they change cleanly with it.
  always_ff @(posedge pixClk) begin
    if (reset) begin
      wState <= W_IDLE;
      addrQ  <= '0;
      dataQ  <= '0;
      oeQ    <= 1'b0;
      nweQ   <= 1'b1;
    end else begin
      wState <= wNext;
      oeQ    <= (wNext != W_IDLE);
      nweQ   <= (wNext != W_STROBE);
      if (loadOut) begin
        addrQ <= head[EW-1:8];
        dataQ <= head[7:0];
      end
    end
  end

  assign bus.vramAddr    = addrQ;
  assign bus.vramDataOut = dataQ;
  assign bus.vramDataOE  = oeQ;
  assign bus.nvramWE     = nweQ;

endmodule

// File: tb/tb_cpu_vram_writer.sv
// Directed self-checking bench for cpu_vram_writer; define ALT_BUFFER_EN to cover the alternate buffer.
module tb_cpu_vram_writer;

  logic       pixClk = 1'b0;
  logic       reset;
  logic       altSel, wrSlot, clrOverflow;
  logic [3:0] fifoLevel;
  logic       overflow;
  int         checks = 0;
  int         errors = 0;

  cpu_vram_writer_if #(.VRAM_AW(15)) bus ();

  cpu_vram_writer #(
    .FB_BASE(24'h3FA700), .FB_BYTES(21888), .VRAM_AW(15),
    .FIFO_DEPTH(8), .ALT_OFFSET(24'h008000)
  ) dut (
    .pixClk(pixClk), .reset(reset), .bus(bus), .altSel(altSel),
    .wrSlot(wrSlot), .clrOverflow(clrOverflow),
    .fifoLevel(fifoLevel), .overflow(overflow)
  );

  always #5 pixClk = ~pixClk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic cpuCycle(input logic [23:0] a, input logic [15:0] d,
                          input logic u, input logic l, input logic rnw);
    @(negedge pixClk);
    bus.cpuAddr = a[23:1];
    bus.cpuData = d;
    bus.cpuRnW  = rnw;
    bus.ncpuAS  = 1'b0;
    bus.ncpuUDS = !u;
    bus.ncpuLDS = !l;
    repeat (6) @(negedge pixClk);
    bus.ncpuAS  = 1'b1;
    bus.ncpuUDS = 1'b1;
    bus.ncpuLDS = 1'b1;
    bus.cpuRnW  = 1'b1;
    repeat (6) @(negedge pixClk);
  endtask

  // Pulse wrSlot and stop on the negedge where nvramWE is low (or the bound expires).
  task automatic slotToStrobe(output bit ok);
    ok = 1'b0;
    @(negedge pixClk);
    wrSlot = 1'b1;
    @(negedge pixClk);
    wrSlot = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (bus.nvramWE === 1'b0) begin
        ok = 1'b1;
        break;
      end
      @(negedge pixClk);
    end
  endtask

  task automatic drainOne(input logic [14:0] expAddr, input logic [7:0] expData, input string name);
    bit ok;
    slotToStrobe(ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s_we_timeout: nvramWE never went low", name);
    end else begin
      checks++; if (bus.vramAddr !== expAddr) begin errors++; $display("FAIL %s_addr: got %h expected %h", name, bus.vramAddr, expAddr); end
      checks++; if (bus.vramDataOut !== expData) begin errors++; $display("FAIL %s_data: got %h expected %h", name, bus.vramDataOut, expData); end
      checks++; if (bus.vramDataOE !== 1'b1) begin errors++; $display("FAIL %s_oe: got %b expected 1", name, bus.vramDataOE); end
      repeat (2) @(negedge pixClk);
      checks++; if (bus.vramDataOE !== 1'b0 || bus.nvramWE !== 1'b1) begin errors++; $display("FAIL %s_idle: got oe=%b we=%b expected oe=0 we=1", name, bus.vramDataOE, bus.nvramWE); end
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (3) @(negedge pixClk);
    checks++; if (bus.nvramWE !== 1'b1) begin errors++; $display("FAIL rst_we: got %b expected 1", bus.nvramWE); end
    checks++; if (bus.vramDataOE !== 1'b0) begin errors++; $display("FAIL rst_oe: got %b expected 0", bus.vramDataOE); end
    checks++; if (bus.vramAddr !== 15'h0) begin errors++; $display("FAIL rst_addr: got %h expected 0", bus.vramAddr); end
    checks++; if (bus.vramDataOut !== 8'h00) begin errors++; $display("FAIL rst_data: got %h expected 0", bus.vramDataOut); end
    checks++; if (fifoLevel !== 4'd0) begin errors++; $display("FAIL rst_level: got %0d expected 0", fifoLevel); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL rst_ovf: got %b expected 0", overflow); end
    reset = 1'b0;
    repeat (3) @(negedge pixClk);
  endtask

  task automatic test_word_write;
    cpuCycle(24'h3FA700, 16'hA55A, 1'b1, 1'b1, 1'b0);
    checks++; if (fifoLevel !== 4'd2) begin errors++; $display("FAIL word_level: got %0d expected 2", fifoLevel); end
    drainOne(15'h0000, 8'hA5, "word_hi");
    drainOne(15'h0001, 8'h5A, "word_lo");
    checks++; if (fifoLevel !== 4'd0) begin errors++; $display("FAIL word_drained: got %0d expected 0", fifoLevel); end
  endtask

  task automatic test_lds_only;
    cpuCycle(24'h3FA7FF, 16'hFF3C, 1'b0, 1'b1, 1'b0);
    checks++; if (fifoLevel !== 4'd1) begin errors++; $display("FAIL lds_level: got %0d expected 1", fifoLevel); end
    drainOne(15'h00FF, 8'h3C, "lds");
  endtask

  task automatic test_window;
    cpuCycle(24'h3FA6FE, 16'h1111, 1'b1, 1'b1, 1'b0);
    checks++; if (fifoLevel !== 4'd0) begin errors++; $display("FAIL below_base: got %0d expected 0", fifoLevel); end
    cpuCycle(24'h3FFC80, 16'h2222, 1'b1, 1'b1, 1'b0);
    checks++; if (fifoLevel !== 4'd0) begin errors++; $display("FAIL at_limit: got %0d expected 0", fifoLevel); end
    cpuCycle(24'h3FA700, 16'h3333, 1'b1, 1'b1, 1'b1);
    checks++; if (fifoLevel !== 4'd0) begin errors++; $display("FAIL read_cycle: got %0d expected 0", fifoLevel); end
    cpuCycle(24'h3FFC7E, 16'hC3D4, 1'b1, 1'b1, 1'b0);
    checks++; if (fifoLevel !== 4'd2) begin errors++; $display("FAIL last_word: got %0d expected 2", fifoLevel); end
    drainOne(15'h557E, 8'hC3, "last_hi");
    drainOne(15'h557F, 8'hD4, "last_lo");
  endtask

  task automatic test_overflow;
    for (int i = 0; i < 5; i++)
      cpuCycle(24'h3FA710 + 24'(2 * i), {8'h10 + 8'(i), 8'h20 + 8'(i)}, 1'b1, 1'b1, 1'b0);
    checks++; if (fifoLevel !== 4'd8) begin errors++; $display("FAIL ovf_level: got %0d expected 8", fifoLevel); end
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag: got %b expected 1", overflow); end
    @(negedge pixClk); clrOverflow = 1'b1;
    @(negedge pixClk); clrOverflow = 1'b0;
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_clear: got %b expected 0", overflow); end
    drainOne(15'h0010, 8'h10, "ovf_head");
    checks++; if (fifoLevel !== 4'd7) begin errors++; $display("FAIL ovf_after_pop: got %0d expected 7", fifoLevel); end
  endtask

  task automatic test_reset_in_strobe;
    bit ok;
    slotToStrobe(ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL rs_we_timeout: nvramWE never went low");
    end else begin
      checks++; if (bus.vramAddr !== 15'h0011 || bus.vramDataOut !== 8'h20) begin errors++; $display("FAIL rs_entry: got %h/%h expected 0011/20", bus.vramAddr, bus.vramDataOut); end
      reset = 1'b1;
      @(negedge pixClk);
      checks++; if (bus.nvramWE !== 1'b1) begin errors++; $display("FAIL rs_we: got %b expected 1", bus.nvramWE); end
      checks++; if (bus.vramDataOE !== 1'b0) begin errors++; $display("FAIL rs_oe: got %b expected 0", bus.vramDataOE); end
      checks++; if (fifoLevel !== 4'd0) begin errors++; $display("FAIL rs_level: got %0d expected 0", fifoLevel); end
      reset = 1'b0;
      repeat (3) @(negedge pixClk);
    end
  endtask

  task automatic test_alt_buffer;
    altSel = 1'b1;
    repeat (4) @(negedge pixClk);
    cpuCycle(24'h3F2700, 16'h1234, 1'b1, 1'b1, 1'b0);
`ifdef ALT_BUFFER_EN
    checks++; if (fifoLevel !== 4'd2) begin errors++; $display("FAIL alt_level: got %0d expected 2", fifoLevel); end
    drainOne(15'h0000, 8'h12, "alt_hi");
    drainOne(15'h0001, 8'h34, "alt_lo");
`else
    checks++; if (fifoLevel !== 4'd0) begin errors++; $display("FAIL alt_ignored: got %0d expected 0", fifoLevel); end
`endif
    altSel = 1'b0;
    repeat (4) @(negedge pixClk);
    cpuCycle(24'h3F2700, 16'h1234, 1'b1, 1'b1, 1'b0);
    checks++; if (fifoLevel !== 4'd0) begin errors++; $display("FAIL alt_off: got %0d expected 0", fifoLevel); end
  endtask

  initial begin
    reset       = 1'b1;
    altSel      = 1'b0;
    wrSlot      = 1'b0;
    clrOverflow = 1'b0;
    bus.cpuAddr = '0;
    bus.cpuData = '0;
    bus.ncpuAS  = 1'b1;
    bus.ncpuUDS = 1'b1;
    bus.ncpuLDS = 1'b1;
    bus.cpuRnW  = 1'b1;
    test_reset();
    test_word_write();
    test_lds_only();
    test_window();
    test_overflow();
    test_reset_in_strobe();
    test_alt_buffer();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
